// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential multiplier.
package mul_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
    localparam int MUL_W    = 16;
    localparam int MUL_ITER = 16;
endpackage

// File: rtl/seq_mul_16_rca.sv
// 16-bit ripple-carry adder used as the single iteration adder of the multiplier.
module seq_mul_16_rca
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             cin,
    output logic [MUL_W-1:0] sum,
    output logic             cout
);
    logic [MUL_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < MUL_W; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[MUL_W];
endmodule

// File: rtl/seq_mul_16.sv
// 16x16 unsigned shift-and-add multiplier: one add per cycle, 32-bit product over valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | 16 add/shift iterations, counted by count
// DONE  | product valid, held until out_ready
module seq_mul_16
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    if (WIDTH != 16) begin : g_bad_width
        $error("seq_mul_16: WIDTH must be 16 to match the iteration adder");
    end
    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
        $error("seq_mul_16: CNT_W too narrow for WIDTH iterations");
    end

    mul_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    assign add_b = q_q[0] ? m_q : '0;

    seq_mul_16_rca u_adder (
        .a    (a_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    // Gate the product so stale datapath contents never leak after a flush.
    assign product   = out_valid ? {a_q, q_q} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            count <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            m_q   <= multiplicand;
            q_q   <= multiplier;
            a_q   <= '0;
            count <= '0;
            state <= BUSY;
        end else begin
            case (state)
                BUSY: begin
                    // Carry-out lands in A's MSB, so the shifted pair never overflows.
                    a_q   <= {add_cout, add_sum[WIDTH-1:1]};
                    q_q   <= {add_sum[0], q_q[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_16.sv
// Directed and random checks of seq_mul_16 against hand-computed products.
module tb_seq_mul_16;
    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int vectors;
    int miscompares;

    seq_mul_16 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return just after the edge that accepted them.
    task automatic accept_op(input logic [15:0] m, input logic [15:0] q);
        int guard;
        guard = 0;
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid     = 1'b0;
        multiplicand = 16'hDEAD;
        multiplier   = 16'hBEEF;
    endtask

    // Edges from just after the accept edge until out_valid; capped at 60.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b product=%h busy=%b, required 1 0 00000000 0",
                     in_ready, out_valid, product, busy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        accept_op(16'h0003, 16'h0005);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL basic_latency: edges after accept=%0d, required 16 (17 incl. accept)", cyc);
        end
        vectors++;
        if (product !== 32'h0000000F || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_product: product=%h in_ready=%b, required 0000000f 1", product, in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || product !== 32'h0) begin
            miscompares++;
            $display("FAIL basic_release: out_valid=%b product=%h, required 0 00000000", out_valid, product);
        end
    endtask

    task automatic test_carry();
        int cyc;
        out_ready = 1'b1;
        accept_op(16'hFFFF, 16'hFFFF);
        wait_done(cyc);
        vectors++;
        if (product !== 32'hFFFE0001) begin
            miscompares++;
            $display("FAIL carry_max: product=%h, required fffe0001", product);
        end
        tick();
        accept_op(16'h8000, 16'h0002);
        wait_done(cyc);
        vectors++;
        if (product !== 32'h00010000) begin
            miscompares++;
            $display("FAIL carry_shift: product=%h, required 00010000", product);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b0;
        accept_op(16'h00FF, 16'h0101);
        wait_done(cyc);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || product !== 32'h0000FFFF || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: out_valid=%b product=%h in_ready=%b, required 1 0000ffff 0",
                         i, out_valid, product, in_ready);
            end
            tick();
        end
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        multiplicand = 16'h1234;
        multiplier   = 16'h0010;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid     = 1'b0;
        multiplicand = 16'h0000;
        multiplier   = 16'h0000;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 16 || product !== 32'h00012340) begin
            miscompares++;
            $display("FAIL b2b_product: edges=%0d product=%h, required 16 00012340", cyc, product);
        end
        tick();
    endtask

    task automatic test_flush();
        int cyc;
        bit seen;
        out_ready = 1'b1;
        accept_op(16'hAAAA, 16'h5555);
        repeat (7) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b, required 0 1 0", busy, in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_no_valid: out_valid rose=%b, required 0", seen);
        end
        flush        = 1'b1;
        in_valid     = 1'b1;
        multiplicand = 16'h0002;
        multiplier   = 16'h0002;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wins: busy=%b, required 0", busy);
        end
        accept_op(16'd7, 16'd9);
        wait_done(cyc);
        vectors++;
        if (product !== 32'h0000003F) begin
            miscompares++;
            $display("FAIL flush_next_op: product=%h, required 0000003f", product);
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        accept_op(16'hFFFF, 16'h00FF);
        repeat (10) tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 32'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b out_valid=%b product=%h in_ready=%b, required 0 0 00000000 1",
                     busy, out_valid, product, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int cyc;
        logic [15:0] m;
        logic [15:0] q;
        logic [31:0] expect_p;
        for (int n = 0; n < 1000; n++) begin
            m = 16'($urandom_range(0, 16'hFFFF));
            q = 16'($urandom_range(0, 16'hFFFF));
            expect_p = 32'(m) * 32'(q);
            out_ready = 1'b0;
            accept_op(m, q);
            wait_done(cyc);
            repeat ($urandom_range(0, 3)) tick();
            vectors++;
            if (out_valid !== 1'b1 || product !== expect_p) begin
                miscompares++;
                $display("FAIL random[%0d]: %h*%h out_valid=%b product=%h, required 1 %h",
                         n, m, q, out_valid, product, expect_p);
            end
            out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = 16'h0;
        multiplier   = 16'h0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
